// File: rtl/core_pkg.sv
// Shared core definitions: register-file defaults, x0 index, register index type, opcodes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_pkg;

   // Default datapath width and register count for the integer register file
   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int REG_AW    = $clog2(NREGS_DEF);

   // Architectural zero register; reads are hardwired to 0, writes are discarded
   localparam int REG_ZERO  = 0;

   // Register index as seen by decode for the default register count
   typedef logic [REG_AW-1:0] reg_idx_t;

   // Processor-level opcode that halts the core
   localparam logic [6:0] OP_HALT = 7'b1111111;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, write-first bypass, x0 forcing, pending-write flag.
// Latency: zero cycles, purely combinational from address/write-back to data/busy.
// Backpressure: none; the busy flag feeds the scoreboard's stall instead of holding the port.
module regfile_read_port
   import core_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] reg_val [NREGS],
   input  logic [NREGS-1:0] busy_vec,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_busy
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic is_zero;
   logic wr_hit;

   // Select the stored value, let a same-cycle write-back win, and force x0 to read as zero
   always_comb begin
      is_zero = (rd_addr == ZERO_IDX);
      wr_hit  = wr_en && (wr_addr == rd_addr) && !is_zero;
      rd_data = reg_val[rd_addr];
      rd_busy = busy_vec[rd_addr];
      if (is_zero) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if (wr_hit) begin
         // The bypassed value is the one the pending write was going to deliver
         rd_data = wr_data;
         rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy bits, RAW/WAW stall and reserved-register count.
// Latency: reads and stall are combinational; writes and reservations take effect at the next edge.
// Backpressure: stall asks the issue stage to hold; a reservation presented while stalled is dropped.
module regfile_scoreboard
   import core_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREAD*AW-1:0]         rd_addr,
   input  logic [NREAD-1:0]            rd_use,
   output logic [NREAD*XLEN-1:0]       rd_data,
   output logic [NREAD-1:0]            rd_busy,
   input  logic                        resv_en,
   input  logic [AW-1:0]               resv_addr,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [XLEN-1:0]             wr_data,
   output logic                        stall,
   output logic [$clog2(NREGS+1)-1:0]  busy_count
);

   localparam int              CW       = $clog2(NREGS+1);
   localparam logic [AW-1:0]   ZERO_IDX = AW'(REG_ZERO);

   // Architectural state
   logic [XLEN-1:0]  mem_q [NREGS];
   logic [XLEN-1:0]  mem_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // Decoded control
   logic wr_act;      // write-back seen by the read bypass (suppressed while in reset)
   logic wr_we;       // write-back that actually updates a register
   logic wr_clr;      // write-back that retires an outstanding reservation
   logic raw;
   logic waw;
   logic resv_take;

   // A write-back arriving while reset is held must not leak onto the read ports
   assign wr_act = wr_en && rst_n;

   genvar g;
   generate
      for (g = 0; g < NREAD; g++) begin : g_rd
         regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
         ) u_rd (
            .rd_addr  (rd_addr[g*AW +: AW]),
            .reg_val  (mem_q),
            .busy_vec (busy_q),
            .wr_en    (wr_act),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[g*XLEN +: XLEN]),
            .rd_busy  (rd_busy[g])
         );
      end
   endgenerate

   // Hazard detection and the reservation accept decision
   always_comb begin
      wr_we     = wr_act && (wr_addr != ZERO_IDX);
      wr_clr    = wr_we && busy_q[wr_addr];
      raw       = |(rd_use & rd_busy);
      // Re-reserving a register whose write-back lands this cycle is safe: the old write retires first
      waw       = resv_en && (resv_addr != ZERO_IDX) && busy_q[resv_addr]
                  && !(wr_act && (wr_addr == resv_addr));
      stall     = raw || waw;
      resv_take = resv_en && !stall && (resv_addr != ZERO_IDX);
   end

   // Next register contents: only a nonzero write-back destination changes
   always_comb begin
      mem_d = mem_q;
      if (wr_we) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Next busy vector: the clear is applied before the set so a same-register new reservation wins
   always_comb begin
      busy_d = busy_q;
      if (wr_we) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (resv_take) begin
         busy_d[resv_addr] = 1'b1;
      end
      busy_d[ZERO_IDX] = 1'b0;
   end

   // Reserved-register count tracks set bits incrementally; retire and take in one edge cancel
   always_comb begin
      cnt_d = cnt_q;
      if (resv_take && !wr_clr) begin
         cnt_d = cnt_q + CW'(1);
      end else if (wr_clr && !resv_take) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // State registers; reset empties the file and the scoreboard immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_count = cnt_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file with an integrated busy-bit scoreboard. It is the next-generation replacement for the core's ad-hoc register array and combinational write-back.
- Provides NREAD combinational read ports with write-first bypass, one clocked write-back port, and hardwired zero register x0.
- Per-register reservation tracks writes still in flight (multi-cycle loads and ALU ops).
- Produces a stall for RAW and WAW hazards; the decode/issue stage uses it to hold the PC.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers. Must be a power of two, at least 2.
- NREAD, 2, number of read ports, 1 to 4.
- AW, $clog2(NREGS), register index width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NREAD*AW  read indices; port i occupies [i*AW +: AW].
- rd_use  in  NREAD  port i is consumed by the current instruction.
- rd_data  out  NREAD*XLEN  read data; port i occupies [i*XLEN +: XLEN].
- rd_busy  out  NREAD  port i's register has an unresolved pending write.
- resv_en  in  1  issuing instruction will write resv_addr later.
- resv_addr  in  AW  destination to reserve.
- wr_en  in  1  write-back valid.
- wr_addr  in  AW  write-back destination.
- wr_data  in  XLEN  write-back value.
- stall  out  1  hazard; issue stage must hold.
- busy_count  out  $clog2(NREGS+1)  number of registers currently reserved.

Behaviour:
- Reset (async assert, sync release):
  - all registers are 0, all busy bits 0, busy_count is 0.
  - stall is 0, rd_busy is 0 and rd_data is 0 immediately, without waiting for a clock edge.
- x0:
  - reads always return 0 and rd_busy is 0.
  - writes and reservations to index 0 are ignored.
- Read path is combinational, zero latency. For each port i:
  - If wr_en is 1 and wr_addr equals rd_addr[i] (nonzero), rd_data[i] is wr_data (write-first bypass).
  - Otherwise rd_data[i] is the stored value.
  - rd_busy[i] is busy[rd_addr[i]] AND NOT (wr_en AND wr_addr equals rd_addr[i]), because the bypass resolves the hazard.
- Write: on the rising clk edge with wr_en=1 and wr_addr nonzero, reg[wr_addr] takes wr_data and busy[wr_addr] is cleared.
- Hazard:
  - raw is the OR over i of (rd_use[i] AND rd_busy[i]).
  - waw is resv_en AND resv_addr nonzero AND busy[resv_addr] AND NOT (wr_en AND wr_addr equals resv_addr).
  - stall is raw OR waw, combinational.
- Reservation: resv_take is resv_en AND NOT stall AND resv_addr nonzero. On the rising edge, resv_take sets busy[resv_addr]. A reservation attempted while stalled is dropped; the issuer re-presents it.
- Same register and same edge, write clear plus resv_take:
  - data is written and busy ends at 1 (the new reservation wins).
  - busy_count is unchanged.
- busy_count:
  - updates on each rising edge by +1 for resv_take and -1 for a write that clears a set busy bit; the two net to 0 when both occur.
  - A write to a non-busy register does not decrement.
  - Never underflows; never exceeds NREGS-1.
- Writes without a prior reservation are legal: data updates and busy stays 0.
- Reset asserted mid-operation clears all busy bits and data; any in-flight write-back after release lands normally with no busy effect.

Decomposition:
- Shared package (core_pkg): XLEN default, REG_ZERO constant (0), register-index typedef (AW bits), and the opcode constant for HALT (7'b1111111) for the processor.
- One natural sub-module, regfile_read_port, instantiated NREAD times. It implements the index mux, write-first bypass, x0 forcing and the rd_busy term. The storage, busy vector, counter and stall logic stay in the top.

Test Plan:
- Reset, then read x1 and x5: rd_data is 0 and rd_busy is 0. Write x1=10 and x2=20, then read both on the next cycle: returns 10 and 20.
- Same-cycle bypass: wr_en=1, wr_addr=3, wr_data=15, rd_addr[0]=3 → rd_data[0]=15 that cycle; after the edge, the stored value is 15.
- RAW: reserve x5 (busy_count becomes 1), then present rd_addr[1]=5, rd_use[1]=1 → stall=1 until write-back of x5=30. In that write-back cycle stall=0 and rd_data[1]=30; busy_count returns to 0.
- WAW: reserve x4, then resv_en on x4 again with no write → stall=1 and the reservation is dropped. Present it together with the write-back of x4 → accepted; busy[x4] stays 1 and busy_count stays 1.
- x0 and unreserved writes: write x0=99 and reserve x0 → reads 0, busy_count 0. Write x7=5 unreserved → busy_count stays 0.
- Async reset mid-stall: with x5 reserved and stall=1, pulse rst_n low between edges → stall, busy_count and all data drop to 0 immediately.
